// File: rtl/vertex_rasterize_fx_if.sv
`default_nettype none
// ============================================================================
//  Module      : vertex_rasterize_fx_if
//  Description : Vertex-in / raster-vertex-out stream bundle for the
//                fixed-point vertex rasterizer. The master drives vertices
//                and accepts raster output; the slave is the rasterizer.
//  Revision    : 1.0  initial release
// ============================================================================
interface vertex_rasterize_fx_if #(
  parameter int COORD_W   = 16,
  parameter int PIX_W     = 13,
  parameter int Z_W       = 16,
  parameter int NUM_VERTS = 3
);
  localparam int VIDX_W = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;

  // Vertex input stream
  logic                      in_valid;
  logic                      in_ready;
  logic signed [COORD_W-1:0] in_ndc_x;
  logic signed [COORD_W-1:0] in_ndc_y;
  logic signed [Z_W-1:0]     in_z;

  // Raster vertex output stream
  logic                      out_valid;
  logic                      out_ready;
  logic signed [PIX_W-1:0]   out_x;
  logic signed [PIX_W-1:0]   out_y;
  logic signed [Z_W-1:0]     out_z;
  logic [VIDX_W-1:0]         out_vidx;
  logic                      out_last;
  logic signed [PIX_W-1:0]   bbox_min_x;
  logic signed [PIX_W-1:0]   bbox_max_x;
  logic signed [PIX_W-1:0]   bbox_min_y;
  logic signed [PIX_W-1:0]   bbox_max_y;
  logic                      cull;

  modport master (
    output in_valid, in_ndc_x, in_ndc_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_vidx, out_last,
           bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, cull
  );

  modport slave (
    input  in_valid, in_ndc_x, in_ndc_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_vidx, out_last,
           bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y, cull
  );
endinterface
`default_nettype wire

// File: rtl/vertex_rasterize_fx.sv
`default_nettype none
// ============================================================================
//  Module      : vertex_rasterize_fx
//  Description : Fixed-point NDC -> raster vertex converter. Two-stage pipe
//                (multiply, then shift/saturate/bbox) with a single global
//                enable for backpressure. Groups NUM_VERTS vertices into a
//                primitive and reports its bounding box and cull flag.
//  Revision    : 1.0  initial release
// ============================================================================
module vertex_rasterize_fx #(
  parameter int COORD_W   = 16,
  parameter int FRAC_W    = 14,
  parameter int PIX_W     = 13,
  parameter int Z_W       = 16,
  parameter int NUM_VERTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-2:0]     image_width,
  input  logic [PIX_W-2:0]     image_height,
  vertex_rasterize_fx_if.slave bus
);
  localparam int VIDX_W = (NUM_VERTS > 1) ? $clog2(NUM_VERTS) : 1;
  localparam int P_W    = COORD_W + 1 + PIX_W;

  localparam logic signed [COORD_W:0] C_ONE       = (COORD_W+1)'(64'sd1 <<< FRAC_W);
  localparam logic signed [P_W-1:0]   C_PIX_MAX   = P_W'((64'sd1 <<< (PIX_W-1)) - 64'sd1);
  localparam logic signed [P_W-1:0]   C_PIX_MIN   = ~C_PIX_MAX;
  localparam logic [VIDX_W-1:0]       C_LAST_IDX  = VIDX_W'(NUM_VERTS-1);
  localparam logic signed [Z_W-1:0]   C_Z_MIN     = {1'b1, {(Z_W-1){1'b0}}};
  localparam logic signed [Z_W-1:0]   C_Z_MAX     = {1'b0, {(Z_W-1){1'b1}}};

  // Clamp a full-precision shifted product into the signed raster range.
  function automatic logic signed [PIX_W-1:0] sat_pix(input logic signed [P_W-1:0] v);
    if (v > C_PIX_MAX)      return C_PIX_MAX[PIX_W-1:0];
    else if (v < C_PIX_MIN) return C_PIX_MIN[PIX_W-1:0];
    else                    return v[PIX_W-1:0];
  endfunction

  // Input side
  logic                    w_en, w_accept;
  logic [VIDX_W-1:0]       r_vcnt;
  logic [PIX_W-2:0]        r_lat_w, r_lat_h;
  logic [PIX_W-2:0]        w_dim_w, w_dim_h;
  logic signed [COORD_W:0] w_nx, w_ny_flip;
  logic signed [P_W-1:0]   w_prod_x, w_prod_y;

  // Stage 1 registers
  logic                    r_s1_valid;
  logic signed [P_W-1:0]   r_s1_px, r_s1_py;
  logic signed [Z_W-1:0]   r_s1_z;
  logic [VIDX_W-1:0]       r_s1_vidx;
  logic [PIX_W-2:0]        r_s1_w, r_s1_h;

  // Stage 2 combinational results
  logic signed [P_W-1:0]   w_sh_x, w_sh_y;
  logic signed [PIX_W-1:0] w_x, w_y;
  logic signed [Z_W-1:0]   w_z;
  logic signed [PIX_W-1:0] w_min_x, w_max_x, w_min_y, w_max_y;
  logic                    w_cull;

  // Stage 2 (output) registers
  logic                    r_out_valid;
  logic signed [PIX_W-1:0] r_out_x, r_out_y;
  logic signed [Z_W-1:0]   r_out_z;
  logic [VIDX_W-1:0]       r_out_vidx;
  logic                    r_out_last;
  logic signed [PIX_W-1:0] r_bmin_x, r_bmax_x, r_bmin_y, r_bmax_y;
  logic                    r_cull;

  assign w_en         = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && w_en;
  assign bus.in_ready = w_en;

  // Vertex 0 uses the live dimensions; later vertices use the latched copy.
  assign w_dim_w   = (r_vcnt == '0) ? image_width  : r_lat_w;
  assign w_dim_h   = (r_vcnt == '0) ? image_height : r_lat_h;
  assign w_nx      = {bus.in_ndc_x[COORD_W-1], bus.in_ndc_x};
  assign w_ny_flip = C_ONE - {bus.in_ndc_y[COORD_W-1], bus.in_ndc_y};
  assign w_prod_x  = P_W'(w_nx) * P_W'($signed({1'b0, w_dim_w}));
  assign w_prod_y  = P_W'(w_ny_flip) * P_W'($signed({1'b0, w_dim_h}));

  // Vertex counter and per-primitive dimension latch, stepped per accepted vertex.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vcnt  <= '0;
      r_lat_w <= '0;
      r_lat_h <= '0;
    end else if (w_accept) begin
      r_vcnt <= (r_vcnt == C_LAST_IDX) ? '0 : r_vcnt + 1'b1;
      if (r_vcnt == '0) begin
        r_lat_w <= image_width;
        r_lat_h <= image_height;
      end
    end
  end

  // Stage 1: capture products, depth, index and the primitive's dimensions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_px    <= '0;
      r_s1_py    <= '0;
      r_s1_z     <= '0;
      r_s1_vidx  <= '0;
      r_s1_w     <= '0;
      r_s1_h     <= '0;
    end else if (w_en) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_px   <= w_prod_x;
        r_s1_py   <= w_prod_y;
        r_s1_z    <= bus.in_z;
        r_s1_vidx <= r_vcnt;
        r_s1_w    <= w_dim_w;
        r_s1_h    <= w_dim_h;
      end
    end
  end

  // Stage 2 datapath: floor shift, saturate, negate depth, fold into bbox, cull.
  always_comb begin
    w_sh_x = r_s1_px >>> FRAC_W;
    w_sh_y = r_s1_py >>> FRAC_W;
    w_x    = sat_pix(w_sh_x);
    w_y    = sat_pix(w_sh_y);
    w_z    = (r_s1_z == C_Z_MIN) ? C_Z_MAX : -r_s1_z;
    if (r_s1_vidx == '0) begin
      w_min_x = w_x;
      w_max_x = w_x;
      w_min_y = w_y;
      w_max_y = w_y;
    end else begin
      w_min_x = (w_x < r_bmin_x) ? w_x : r_bmin_x;
      w_max_x = (w_x > r_bmax_x) ? w_x : r_bmax_x;
      w_min_y = (w_y < r_bmin_y) ? w_y : r_bmin_y;
      w_max_y = (w_y > r_bmax_y) ? w_y : r_bmax_y;
    end
    w_cull = (r_s1_w == '0) || (r_s1_h == '0) ||
             w_max_x[PIX_W-1] || (w_min_x >= $signed({1'b0, r_s1_w})) ||
             w_max_y[PIX_W-1] || (w_min_y >= $signed({1'b0, r_s1_h}));
  end

  // Stage 2 registers drive the outputs; bubbles clear valid but keep the bbox.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
      r_out_vidx  <= '0;
      r_out_last  <= 1'b0;
      r_bmin_x    <= '0;
      r_bmax_x    <= '0;
      r_bmin_y    <= '0;
      r_bmax_y    <= '0;
      r_cull      <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_x    <= w_x;
        r_out_y    <= w_y;
        r_out_z    <= w_z;
        r_out_vidx <= r_s1_vidx;
        r_out_last <= (r_s1_vidx == C_LAST_IDX);
        r_bmin_x   <= w_min_x;
        r_bmax_x   <= w_max_x;
        r_bmin_y   <= w_min_y;
        r_bmax_y   <= w_max_y;
        r_cull     <= w_cull;
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_x      = r_out_x;
  assign bus.out_y      = r_out_y;
  assign bus.out_z      = r_out_z;
  assign bus.out_vidx   = r_out_vidx;
  assign bus.out_last   = r_out_last;
  assign bus.bbox_min_x = r_bmin_x;
  assign bus.bbox_max_x = r_bmax_x;
  assign bus.bbox_min_y = r_bmin_y;
  assign bus.bbox_max_y = r_bmax_y;
  assign bus.cull       = r_cull;
endmodule
`default_nettype wire

// File: tb/tb_vertex_rasterize_fx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vertex_rasterize_fx
//  Description : Directed self-checking bench for vertex_rasterize_fx.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vertex_rasterize_fx;
  localparam int COORD_W   = 16;
  localparam int FRAC_W    = 14;
  localparam int PIX_W     = 13;
  localparam int Z_W       = 16;
  localparam int NUM_VERTS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [PIX_W-2:0] image_width;
  logic [PIX_W-2:0] image_height;

  vertex_rasterize_fx_if #(.COORD_W(COORD_W), .PIX_W(PIX_W), .Z_W(Z_W),
                           .NUM_VERTS(NUM_VERTS)) vif ();

  vertex_rasterize_fx #(.COORD_W(COORD_W), .FRAC_W(FRAC_W), .PIX_W(PIX_W),
                        .Z_W(Z_W), .NUM_VERTS(NUM_VERTS)) dut (
    .clk          (clk),
    .rst          (rst),
    .image_width  (image_width),
    .image_height (image_height),
    .bus          (vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int z; int vidx; int last;
    int bminx; int bmaxx; int bminy; int bmaxy; int cull; int cyc;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;
  int   last_acc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output transfer once, at the negedge before its handshake edge.
  always @(negedge clk) begin
    rec_t r;
    if (rst && vif.out_valid && vif.out_ready) begin
      r.x = vif.out_x;         r.y = vif.out_y;         r.z = vif.out_z;
      r.vidx = vif.out_vidx;   r.last = vif.out_last;
      r.bminx = vif.bbox_min_x; r.bmaxx = vif.bbox_max_x;
      r.bminy = vif.bbox_min_y; r.bmaxy = vif.bbox_max_y;
      r.cull = vif.cull;       r.cyc = cyc;
      q.push_back(r);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Offer one vertex starting at posedge+1; returns at posedge+1 after its handshake.
  task automatic send(input int nx, input int ny, input int z);
    bit ok;
    ok = 1'b0;
    vif.in_valid = 1'b1;
    vif.in_ndc_x = COORD_W'(nx);
    vif.in_ndc_y = COORD_W'(ny);
    vif.in_z     = Z_W'(z);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = vif.in_ready;
      @(posedge clk); #1;
    end
    last_acc = cyc;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    vif.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 100 && q.size() < n; i++) @(negedge clk);
    if (q.size() < n) chk("out_timeout", q.size(), n);
  endtask

  task automatic pop(output rec_t r);
    if (q.size() > 0) r = q.pop_front();
    else r = '{default: 0};
  endtask

  task automatic apply_reset();
    vif.in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rec_t r0, r1, r2, r;
    int a0;
    vif.in_valid = 1'b0; vif.in_ndc_x = '0; vif.in_ndc_y = '0; vif.in_z = '0;
    vif.out_ready = 1'b1;
    image_width = 640; image_height = 480;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_out_valid", vif.out_valid, 0);
    chk("rst_in_ready",  vif.in_ready, 1);
    chk("rst_out_x",     vif.out_x, 0);
    chk("rst_out_z",     vif.out_z, 0);
    chk("rst_bbox_max_y", vif.bbox_max_y, 0);
    chk("rst_cull",      vif.cull, 0);
    rst = 1'b1;

    // Single vertex and latency
    send(8192, 4096, -100); a0 = last_acc; idle();
    wait_out(1); pop(r);
    chk("single_x", r.x, 320);
    chk("single_y", r.y, 360);
    chk("single_z", r.z, 100);
    chk("single_vidx", r.vidx, 0);
    chk("single_latency", r.cyc - a0, 1);

    // Triangle
    @(posedge clk); #1;
    apply_reset();
    send(0, 0, -1); send(8192, 8192, -2); send(16384, 16384, -3); idle();
    wait_out(3); pop(r0); pop(r1); pop(r2);
    chk("tri_x0", r0.x, 0);    chk("tri_y0", r0.y, 480);
    chk("tri_x1", r1.x, 320);  chk("tri_y1", r1.y, 240);
    chk("tri_x2", r2.x, 640);  chk("tri_y2", r2.y, 0);
    chk("tri_vidx1", r1.vidx, 1);
    chk("tri_last0", r0.last, 0); chk("tri_last2", r2.last, 1);
    chk("tri_bminx", r2.bminx, 0);  chk("tri_bmaxx", r2.bmaxx, 640);
    chk("tri_bminy", r2.bminy, 0);  chk("tri_bmaxy", r2.bmaxy, 480);
    chk("tri_cull", r2.cull, 0);
    chk("tri_z2", r2.z, 3);
    chk("tri_throughput", r2.cyc - r0.cyc, 2);

    // Off-screen primitive
    @(posedge clk); #1;
    apply_reset();
    repeat (3) send(-8192, 8192, 0);
    idle();
    wait_out(3); pop(r0); pop(r1); pop(r2);
    chk("off_x0", r0.x, -320);
    chk("off_bmaxx", r2.bmaxx, -320);
    chk("off_cull", r2.cull, 1);

    // Zero width
    @(posedge clk); #1;
    apply_reset();
    image_width = 0;
    repeat (3) send(-8192, 8192, 0);
    idle();
    wait_out(3); pop(r0); pop(r1); pop(r2);
    chk("w0_x0", r0.x, 0);
    chk("w0_y0", r0.y, 240);
    chk("w0_cull", r2.cull, 1);

    // Saturation, depth saturation, mid-primitive dimension change
    @(posedge clk); #1;
    apply_reset();
    image_width = 4095;
    send(32767, 8192, -32768);
    image_width = 640;
    send(-32768, 8192, 5);
    send(0, -16384, 0);
    idle();
    wait_out(3); pop(r0); pop(r1); pop(r2);
    chk("sat_x_pos", r0.x, 4095);
    chk("sat_z", r0.z, 32767);
    chk("sat_x_neg_latched", r1.x, -4096);
    chk("neg_z", r1.z, -5);
    chk("sat_y2", r2.y, 960);
    chk("sat_bminx", r2.bminx, -4096); chk("sat_bmaxx", r2.bmaxx, 4095);
    chk("sat_bminy", r2.bminy, 240);   chk("sat_bmaxy", r2.bmaxy, 960);
    chk("sat_cull", r2.cull, 0);

    // Floor rounding on a new primitive (picks up width 640)
    @(posedge clk); #1;
    repeat (3) send(-1, 16384, 0);
    idle();
    wait_out(3); pop(r0); pop(r1); pop(r2);
    chk("floor_x", r0.x, -1);
    chk("floor_y", r0.y, 0);
    chk("floor_vidx0", r0.vidx, 0);
    chk("floor_cull", r2.cull, 1);

    // Backpressure
    @(posedge clk); #1;
    apply_reset();
    vif.out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(k * 1024, 8192, -k);
        idle();
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          seen = vif.out_valid;
        end
        chk("bp_seen", seen, 1);
        for (int c = 0; c < 5; c++) begin
          chk("bp_in_ready", vif.in_ready, 0);
          chk("bp_hold_valid", vif.out_valid, 1);
          chk("bp_hold_x", vif.out_x, 0);
          chk("bp_hold_vidx", vif.out_vidx, 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        vif.out_ready = 1'b1;
      end
    join
    wait_out(6);
    repeat (5) @(negedge clk);
    chk("bp_count", q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      pop(r);
      chk("bp_x", r.x, k * 40);
      chk("bp_vidx", r.vidx, k % 3);
    end

    // Reset mid-primitive
    @(posedge clk); #1;
    apply_reset();
    send(8192, 0, 0); send(16384, 0, 0);
    idle();
    chk("mid_pre_valid", vif.out_valid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", vif.out_valid, 0);
    chk("mid_rst_in_ready", vif.in_ready, 1);
    chk("mid_rst_x", vif.out_x, 0);
    chk("mid_rst_bmaxx", vif.bbox_max_x, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    send(4096, 16384, -7); idle();
    wait_out(1); pop(r);
    chk("mid_vidx", r.vidx, 0);
    chk("mid_x", r.x, 160);
    chk("mid_z", r.z, 7);
    chk("mid_bminx", r.bminx, 160); chk("mid_bmaxx", r.bmaxx, 160);
    chk("mid_bminy", r.bminy, 0);   chk("mid_bmaxy", r.bmaxy, 0);
    chk("mid_last", r.last, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vertex_rasterize_fx.md
# vertex_rasterize_fx

Parametrised fixed-point successor to the float vertex rasterizer. It converts a stream of NDC vertices into signed integer raster coordinates plus a negated depth, with a valid/ready handshake and backpressure. It groups every `NUM_VERTS` vertices into one primitive and emits that primitive's screen bounding box and a cull flag with its last vertex. It sits between the projection stage and triangle setup, and needs no vendor float IP.

## Interface
Parameters:
- `COORD_W`, 16: width of signed NDC inputs, format Q(COORD_W-FRAC_W).FRAC_W
- `FRAC_W`, 14: NDC fraction bits; ONE = 2^FRAC_W
- `PIX_W`, 13: width of signed raster outputs; image dims are PIX_W-1 bits unsigned
- `Z_W`, 16: width of signed integer depth in/out
- `NUM_VERTS`, 3: vertices per primitive (≥1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  vertex offered
- `in_ready`  out  1  vertex accepted when in_valid && in_ready
- `in_ndc_x`  in  COORD_W  signed NDC x, nominal [0, ONE]
- `in_ndc_y`  in  COORD_W  signed NDC y, nominal [0, ONE], +y up
- `in_z`  in  Z_W  signed view-space depth (negative in front)
- `image_width`  in  PIX_W-1  unsigned pixels
- `image_height`  in  PIX_W-1  unsigned pixels
- `out_valid`  out  1  raster vertex available
- `out_ready`  in  1  downstream accepts
- `out_x`, `out_y`  out  PIX_W each  signed raster coordinates
- `out_z`  out  Z_W  signed, equal to −in_z
- `out_vidx`  out  $clog2(NUM_VERTS) or 1  vertex index in primitive
- `out_last`  out  1  out_vidx == NUM_VERTS-1
- `bbox_min_x`, `bbox_max_x`, `bbox_min_y`, `bbox_max_y`  out  PIX_W each  primitive bounds, valid when out_valid && out_last
- `cull`  out  1  primitive fully off-screen, valid when out_valid && out_last

## Operation
- Arithmetic, full precision:
  - x = (in_ndc_x · W) >>> FRAC_W
  - y = ((ONE − in_ndc_y) · H) >>> FRAC_W
  - Arithmetic shifts, so results floor toward −∞.
  - Products are COORD_W+1+PIX_W bits wide.
- Saturation:
  - x and y saturate to [−2^(PIX_W−1), 2^(PIX_W−1)−1].
  - z = −in_z; −(−2^(Z_W−1)) saturates to 2^(Z_W−1)−1.
- Vertex counter:
  - Increments on each input handshake.
  - Wraps from NUM_VERTS−1 to 0.
  - Travels down the pipe with its vertex as out_vidx.
- Dimension latch:
  - W and H are latched on the acceptance of vertex 0.
  - The latched values are used for all vertices of that primitive.
  - Dimension changes mid-primitive have no effect until the next vertex 0.
  - When NUM_VERTS=1, dimensions are latched every vertex.
- Bounding-box accumulator (output stage):
  - On vertex 0, min/max load from that vertex.
  - Otherwise they update with signed min/max.
  - The bbox outputs present the accumulated value including the current vertex.
- Cull rule, evaluated with the latched dimensions of that primitive:
  - cull = (max_x < 0) || (min_x ≥ W) || (max_y < 0) || (min_y ≥ H).
  - If W=0 or H=0, cull=1.
- Pipeline:
  - Two register stages: S1 registers inputs and multiplies; S2 shifts, saturates, negates z and updates the bbox.
  - S2 drives the outputs.
  - Global enable en = !out_valid || out_ready.
  - All stages advance only when en=1.
  - in_ready = en.

## Timing
- Latency: a vertex accepted at cycle t appears with out_valid=1 at t+2 when there is no stall. Throughput is 1 vertex/cycle.
- Stall: while out_valid && !out_ready:
  - All outputs hold stable.
  - in_ready=0, combinationally from out_ready.
  - S1 contents are held.
- Bubbles: invalid S1 slots propagate as out_valid=0. Bubbles are not compressed during stalls.
- Reset (asserted low, asynchronous):
  - Clears the S1/S2 valid bits, vertex counter, latched dimensions and bbox registers.
  - out_valid=0, in_ready=1 (since out_valid=0).
  - out_x, out_y, out_z, out_vidx, out_last, bbox_* and cull are all 0.
- Reset mid-primitive: partially received primitives are discarded. The first vertex after release is vertex 0.
- Simultaneous output handshake and new input: both occur in the same cycle, with no bubble inserted.

## Test plan
- **Single vertex:** FRAC_W=14, W=640, H=480; ndc_x=8192, ndc_y=4096, z=−100 -> after 2 cycles out_x=320, out_y=360, out_z=100, out_vidx=0.
- **Triangle:** (0,0), (8192,8192), (16384,16384), out_ready=1 -> x = 0, 320, 640; y = 480, 240, 0; out_last on vertex 2; bbox [0,640]×[0,480]; cull=0.
- **Off-screen and degenerate:**
  - Three vertices with ndc_x=−8192 -> x=−320, cull=1.
  - Repeat with W=0 -> x=0, cull=1.
- **Saturation and rounding:**
  - ndc_x=32767, W=4095 -> out_x=4095.
  - ndc_x=−1, W=640 -> out_x=−1 (floor).
  - in_z=−32768 -> out_z=32767.
- **Backpressure:** stream 6 vertices while holding out_ready=0 for 5 cycles after the first out_valid -> in_ready=0 during the stall, outputs stable, no loss or duplication, vidx sequence 0,1,2,0,1,2.
- **Reset mid-primitive:** assert rst low after vertex 1 is accepted -> out_valid=0 immediately; after release, the next vertex reports out_vidx=0 and its bbox contains only itself.
